// File: rtl/mmio_timer_gpio.sv
// Memory-mapped LED register plus 64-bit prescaled timer with compare/match and IRQ.
// Define MMIO_TIMER_SNAPSHOT_EN to latch MTIME_HI into a shadow on MTIME_LO loads.
module mmio_timer_gpio #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          LED_W     = 18,
  parameter int          PRESC_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      dataW,
  input  logic             MemRW,
  input  logic             MemRd,
  output logic             hit,
  output logic [31:0]      dataR,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  logic [LED_W-1:0]   led_q, led_d;
  logic [31:0]        mtime_lo_q, mtime_lo_d;
  logic [31:0]        mtime_hi_q, mtime_hi_d;
  logic [31:0]        cmp_q, cmp_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic               match_q, match_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  logic [2:0]  sel;
  logic        we;
  logic        wr_led, wr_lo, wr_hi, wr_cmp, wr_ctrl, wr_stat, wr_pre;
  logic        tick, cmp_hit;
  logic [63:0] mtime_inc, mtime_nx;

  // Address bits [1:0] are ignored by design; MemRd only matters with the snapshot.
  logic unused_bits;
  assign unused_bits = ^{MemRd, addr[1:0]};

  assign hit = (addr[31:5] == BASE_ADDR[31:5]);
  assign sel = addr[4:2];
  assign we  = hit & MemRW;

  assign wr_led  = we & (sel == 3'd0);
  assign wr_lo   = we & (sel == 3'd1);
  assign wr_hi   = we & (sel == 3'd2);
  assign wr_cmp  = we & (sel == 3'd3);
  assign wr_ctrl = we & (sel == 3'd4);
  assign wr_stat = we & (sel == 3'd5);
  assign wr_pre  = we & (sel == 3'd6);

  assign tick      = ctrl_q[0] & (pcnt_q == presc_q);
  assign cmp_hit   = (mtime_lo_q == cmp_q);
  assign mtime_inc = {mtime_hi_q, mtime_lo_q} + 64'd1;

  always_comb begin
    mtime_nx = {mtime_hi_q, mtime_lo_q};
    if (tick) begin
      if (cmp_hit && ctrl_q[1]) mtime_nx = 64'd0;
      else                      mtime_nx = mtime_inc;
    end

    // A software write owns only the half it targets; the other half keeps counting.
    mtime_lo_d = wr_lo ? dataW : mtime_nx[31:0];
    mtime_hi_d = wr_hi ? dataW : mtime_nx[63:32];

    led_d   = wr_led  ? dataW[LED_W-1:0]   : led_q;
    cmp_d   = wr_cmp  ? dataW              : cmp_q;
    ctrl_d  = wr_ctrl ? dataW[2:0]         : ctrl_q;
    presc_d = wr_pre  ? dataW[PRESC_W-1:0] : presc_q;

    // Hardware set beats a simultaneous W1C.
    match_d = (match_q & ~(wr_stat & dataW[0])) | (tick & cmp_hit);

    if (wr_pre || wr_ctrl || !ctrl_q[0] || tick) pcnt_d = '0;
    else                                         pcnt_d = pcnt_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      mtime_lo_q <= '0;
      mtime_hi_q <= '0;
      cmp_q      <= '0;
      ctrl_q     <= '0;
      match_q    <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
    end else begin
      led_q      <= led_d;
      mtime_lo_q <= mtime_lo_d;
      mtime_hi_q <= mtime_hi_d;
      cmp_q      <= cmp_d;
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
    end
  end

  logic [31:0] hi_rd;

`ifdef MMIO_TIMER_SNAPSHOT_EN
  logic [31:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (hit && MemRd && sel == 3'd1) shadow_d = mtime_hi_q;
    if (wr_hi)                       shadow_d = dataW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

  assign hi_rd = shadow_q;
`else
  assign hi_rd = mtime_hi_q;
`endif

  always_comb begin
    dataR = 32'd0;
    if (hit) begin
      case (sel)
        3'd0:    dataR[LED_W-1:0]   = led_q;
        3'd1:    dataR              = mtime_lo_q;
        3'd2:    dataR              = hi_rd;
        3'd3:    dataR              = cmp_q;
        3'd4:    dataR[2:0]         = ctrl_q;
        3'd5:    dataR[0]           = match_q;
        3'd6:    dataR[PRESC_W-1:0] = presc_q;
        default: dataR              = 32'd0;
      endcase
    end
  end

  assign led = led_q;
  assign irq = match_q & ctrl_q[2];

endmodule

// File: tb/tb_mmio_timer_gpio.sv
// Directed bench for mmio_timer_gpio: decode, LED, timer reload/prescale/carry, collisions, snapshot.
module tb_mmio_timer_gpio;

  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam logic [31:0] A_LED  = BASE + 32'h00;
  localparam logic [31:0] A_LO   = BASE + 32'h04;
  localparam logic [31:0] A_HI   = BASE + 32'h08;
  localparam logic [31:0] A_CMP  = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL = BASE + 32'h10;
  localparam logic [31:0] A_STAT = BASE + 32'h14;
  localparam logic [31:0] A_PRE  = BASE + 32'h18;
  localparam logic [31:0] A_RSV  = BASE + 32'h1C;

`ifdef MMIO_TIMER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, dataW, dataR;
  logic        MemRW, MemRd, hit, irq;
  logic [17:0] led;

  int vec_cnt = 0;
  int err_cnt = 0;

  mmio_timer_gpio #(.BASE_ADDR(BASE), .LED_W(18), .PRESC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .dataW (dataW),
    .MemRW (MemRW),
    .MemRd (MemRd),
    .hit   (hit),
    .dataR (dataR),
    .led   (led),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("pass %s: %h", tag, got);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Store spans exactly one rising edge and returns on the following falling edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    dataW = d;
    MemRW = 1'b1;
    @(negedge clk);
    MemRW = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check_val(tag, dataR, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = 32'd0;
    dataW = 32'd0;
    MemRW = 1'b0;
    MemRd = 1'b0;
    nclk(2);
    check_val("rst_led", 32'(led), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    rd_chk("rst_lo", A_LO, 32'd0);
    rst_n = 1'b1;
    nclk(1);

    // LED register width
    bus_wr(A_LED, 32'hFFFF_FFFF);
    check_val("led_out", 32'(led), 32'h0003_FFFF);
    rd_chk("led_rd", A_LED, 32'h0003_FFFF);

    // Decode window edges
    bus_wr(BASE + 32'h20, 32'h1234);
    check_val("dec_above_hit", 32'(hit), 32'd0);
    check_val("dec_above_rd", dataR, 32'd0);
    bus_wr(BASE - 32'h4, 32'h1234);
    check_val("dec_below_hit", 32'(hit), 32'd0);
    check_val("dec_led_kept", 32'(led), 32'h0003_FFFF);
    rd_chk("dec_cmp_kept", A_CMP, 32'd0);
    bus_wr(A_RSV, 32'hFFFF_FFFF);
    rd_chk("rsv_rd", A_RSV, 32'd0);
    bus_wr(A_CTRL, 32'hFFFF_FFF8);
    rd_chk("ctrl_upper", A_CTRL, 32'd0);

    // Auto-reload, period 6
    bus_wr(A_PRE, 32'd0);
    bus_wr(A_CMP, 32'd5);
    bus_wr(A_CTRL, 32'd3);
    rd_chk("ar_lo0", A_LO, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      nclk(1);
      rd_chk($sformatf("ar_lo%0d", k), A_LO, 32'(k));
      rd_chk($sformatf("ar_st%0d", k), A_STAT, 32'd0);
    end
    nclk(1);
    rd_chk("ar_wrap_lo", A_LO, 32'd0);
    rd_chk("ar_wrap_st", A_STAT, 32'd1);
    bus_wr(A_STAT, 32'd1);
    rd_chk("w1c_st", A_STAT, 32'd0);
    rd_chk("w1c_lo", A_LO, 32'd1);
    nclk(4);
    rd_chk("ar2_lo5", A_LO, 32'd5);
    rd_chk("ar2_st0", A_STAT, 32'd0);
    nclk(1);
    rd_chk("ar2_lo0", A_LO, 32'd0);
    rd_chk("ar2_st1", A_STAT, 32'd1);

    // W1C on the exact match-set edge
    bus_wr(A_STAT, 32'd1);
    rd_chk("col_clr", A_STAT, 32'd0);
    nclk(4);
    rd_chk("col_lo5", A_LO, 32'd5);
    bus_wr(A_STAT, 32'd1);
    rd_chk("col_set_wins", A_STAT, 32'd1);
    rd_chk("col_lo0", A_LO, 32'd0);

    // Software write beats increment
    bus_wr(A_LO, 32'h100);
    rd_chk("col_lo_wr", A_LO, 32'h100);
    rd_chk("col_hi", A_HI, 32'd0);

    // irq gating
    check_val("irq_en0", 32'(irq), 32'd0);
    bus_wr(A_CTRL, 32'd7);
    rd_chk("ctrl_rd", A_CTRL, 32'd7);
    check_val("irq_on", 32'(irq), 32'd1);
    bus_wr(A_STAT, 32'd1);
    check_val("irq_nomatch", 32'(irq), 32'd0);

    // Prescale and LO->HI carry
    bus_wr(A_CTRL, 32'd0);
    bus_wr(A_PRE, 32'd3);
    bus_wr(A_HI, 32'd0);
    bus_wr(A_LO, 32'hFFFF_FFFE);
    bus_wr(A_CTRL, 32'd1);
    rd_chk("pre_rd", A_PRE, 32'd3);
    rd_chk("pre_lo_c0", A_LO, 32'hFFFF_FFFE);
    nclk(3);
    rd_chk("pre_lo_c3", A_LO, 32'hFFFF_FFFE);
    nclk(1);
    rd_chk("pre_lo_c4", A_LO, 32'hFFFF_FFFF);
    nclk(3);
    rd_chk("pre_lo_c7", A_LO, 32'hFFFF_FFFF);
    nclk(1);
    rd_chk("pre_lo_c8", A_LO, 32'd0);
    rd_chk("pre_hi_c8", A_HI, SNAP ? 32'd0 : 32'd1);

    // HI write on a carry tick: LO still wraps, HI takes the written value
    bus_wr(A_CTRL, 32'd0);
    bus_wr(A_PRE, 32'd0);
    bus_wr(A_HI, 32'hFFFF_FFFF);
    bus_wr(A_LO, 32'hFFFF_FFFF);
    bus_wr(A_CTRL, 32'd1);
    bus_wr(A_HI, 32'h55);
    rd_chk("split_lo", A_LO, 32'd0);
    rd_chk("split_hi", A_HI, 32'h55);

    // Full 64-bit wrap
    bus_wr(A_CTRL, 32'd0);
    bus_wr(A_LO, 32'hFFFF_FFFF);
    bus_wr(A_HI, 32'hFFFF_FFFF);
    bus_wr(A_CTRL, 32'd1);
    nclk(1);
    rd_chk("wrap_lo", A_LO, 32'd0);
    rd_chk("wrap_hi", A_HI, SNAP ? 32'hFFFF_FFFF : 32'd0);

    // CMP written on a tick: old CMP (5) is compared, so LO=1 does not match
    bus_wr(A_CTRL, 32'd7);
    bus_wr(A_CMP, 32'd1);
    rd_chk("cmpwr_st", A_STAT, 32'd0);
    rd_chk("cmpwr_lo", A_LO, 32'd2);
    bus_wr(A_LO, 32'd0);
    nclk(2);
    rd_chk("cmp1_st", A_STAT, 32'd1);
    rd_chk("cmp1_lo", A_LO, 32'd0);
    check_val("cmp1_irq", 32'(irq), 32'd1);

    // Asynchronous reset mid-count, observed before any clock edge
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_led", 32'(led), 32'd0);
    check_val("arst_irq", 32'(irq), 32'd0);
    rd_chk("arst_lo", A_LO, 32'd0);
    rd_chk("arst_ctrl", A_CTRL, 32'd0);
    rd_chk("arst_cmp", A_CMP, 32'd0);
    nclk(1);
    rst_n = 1'b1;
    nclk(1);

    // Snapshot: HI read after a LO load returns the latched value when compiled in
    bus_wr(A_HI, 32'd7);
    bus_wr(A_LO, 32'hFFFF_FFFF);
    bus_wr(A_CTRL, 32'd1);
    addr  = A_LO;
    MemRd = 1'b1;
    #1;
    check_val("snap_lo", dataR, 32'hFFFF_FFFF);
    nclk(1);
    MemRd = 1'b0;
    nclk(1);
    rd_chk("snap_hi", A_HI, SNAP ? 32'd7 : 32'd8);
    addr  = A_LO;
    MemRd = 1'b1;
    nclk(1);
    MemRd = 1'b0;
    rd_chk("snap_hi2", A_HI, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
